// File: rtl/block_interleaver_pkg.sv
// Shared definitions for the block interleaver: frame sizing, the row/column
// index maps used to build the permutation network, and parameter legality.
package block_interleaver_pkg;

   // Frame mode latched with the first byte of every frame
   typedef enum logic {
      MODE_IL  = 1'b0,
      MODE_DIL = 1'b1
   } il_mode_e;

   localparam int BYTE_BITS = 32'sd8;

   // Number of bits in one frame
   function automatic int frame_bits(input int rows, input int cols);
      return rows * cols;
   endfunction

   // Number of bytes in one frame
   function automatic int frame_bytes(input int rows, input int cols);
      return (rows * cols) / BYTE_BITS;
   endfunction

   // Interleave: bits are written row by row and read column by column
   function automatic int il_index(input int k, input int rows, input int cols);
      int r;
      int c;
      r = k / cols;
      c = k % cols;
      return (c * rows) + r;
   endfunction

   // De-interleave: exact inverse of il_index
   function automatic int dil_index(input int k, input int rows, input int cols);
      int r;
      int c;
      c = k / rows;
      r = k % rows;
      return (r * cols) + c;
   endfunction

   // Matrix must be at least 2x2 and hold a whole number of bytes
   function automatic bit params_legal(input int rows, input int cols);
      return (rows >= 32'sd2) && (cols >= 32'sd2) && (((rows * cols) % BYTE_BITS) == 32'sd0);
   endfunction

endpackage

// File: rtl/block_interleaver_perm.sv
// Combinational ROWS x COLS permutation network. Bit k of the received frame
// sits at a[N-1-k]; output position j is driven onto p[N-1-j].
module block_interleaver_perm
   import block_interleaver_pkg::*;
#(
   parameter  int ROWS = 8,
   parameter  int COLS = 8,
   localparam int N    = ROWS * COLS
)(
   input  logic [N-1:0] a,
   input  logic         mode,
   output logic [N-1:0] p
);

   logic [N-1:0] il_s;
   logic [N-1:0] dil_s;

   for (genvar k = 0; k < N; k++) begin : g_bit
      assign il_s[N-1-il_index(k, ROWS, COLS)]   = a[N-1-k];
      assign dil_s[N-1-dil_index(k, ROWS, COLS)] = a[N-1-k];
   end

   // Select the forward or inverse mapping for this frame
   always_comb begin
      p = il_s;
      if (il_mode_e'(mode) == MODE_DIL) begin
         p = dil_s;
      end else begin
         p = il_s;
      end
   end

endmodule

// File: rtl/block_interleaver.sv
// Block interleaver/de-interleaver top: byte assembly register A feeding a
// valid/ready output register B through the permutation network.
// Optional feature macro: BLOCK_INTERLEAVER_RAW_OUT_EN adds o_Raw_Frame, the
// un-permuted frame captured alongside o_Frame.
module block_interleaver
   import block_interleaver_pkg::*;
#(
   parameter  int ROWS = 8,
   parameter  int COLS = 8,
   localparam int N    = frame_bits(ROWS, COLS),
   localparam int NB   = frame_bytes(ROWS, COLS)
)(
   input  logic         clk,
   input  logic         rst,
   input  logic [7:0]   i_Byte,
   input  logic         i_Byte_Valid,
   input  logic         i_Deinterleave,
   input  logic         i_Frame_Abort,
   output logic [N-1:0] o_Frame,
   output logic         o_Frame_Valid,
   input  logic         i_Frame_Ready,
   output logic         o_Frame_Mode,
   output logic         o_Overflow
`ifdef BLOCK_INTERLEAVER_RAW_OUT_EN
   ,
   output logic [N-1:0] o_Raw_Frame
`endif
);

   localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;

   if (!params_legal(ROWS, COLS)) begin : g_param_check
      $error("block_interleaver: ROWS and COLS must be >= 2 and ROWS*COLS a multiple of 8");
   end

   // Assembly stage A
   logic [N-1:0]     a_r;
   logic [CNT_W-1:0] cnt_r;
   logic             full_r;
   logic             amode_r;

   logic [N-1:0]     a_nxt_s;
   logic [N-1:0]     shift_s;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic             full_nxt_s;
   logic             mode_nxt_s;

   logic             b_free_s;
   logic             xfer_full_s;
   logic             abort_s;
   logic             take_s;
   logic             drop_s;
   logic             fast_s;
   logic             load_b_s;
   logic [N-1:0]     perm_in_s;
   logic             perm_mode_s;
   logic [N-1:0]     perm_out_s;

   block_interleaver_perm #(
      .ROWS (ROWS),
      .COLS (COLS)
   ) u_perm (
      .a    (perm_in_s),
      .mode (perm_mode_s),
      .p    (perm_out_s)
   );

   // Next-state of A and the A->B hand-off; a frame completed this cycle goes
   // straight to B when B is free so the output lags the last byte by one edge
   always_comb begin
      b_free_s    = ~o_Frame_Valid | i_Frame_Ready;
      xfer_full_s = full_r & b_free_s;
      abort_s     = i_Frame_Abort & ~full_r;
      take_s      = i_Byte_Valid & ~abort_s & (~full_r | xfer_full_s);
      drop_s      = i_Byte_Valid & ~abort_s & ~take_s;

      a_nxt_s     = a_r;
      shift_s     = {N{1'b0}};
      cnt_nxt_s   = cnt_r;
      full_nxt_s  = full_r;
      mode_nxt_s  = amode_r;

      // A full frame moving to B frees A for a byte arriving in the same cycle
      if (xfer_full_s) begin
         a_nxt_s    = {N{1'b0}};
         cnt_nxt_s  = {CNT_W{1'b0}};
         full_nxt_s = 1'b0;
      end else begin
         a_nxt_s    = a_r;
      end

      if (abort_s) begin
         a_nxt_s   = {N{1'b0}};
         cnt_nxt_s = {CNT_W{1'b0}};
      end else if (take_s) begin
         shift_s      = a_nxt_s << 4'd8;
         shift_s[7:0] = i_Byte;
         a_nxt_s      = shift_s;
         if (cnt_nxt_s == {CNT_W{1'b0}}) begin
            mode_nxt_s = i_Deinterleave;
         end else begin
            mode_nxt_s = amode_r;
         end
         if (cnt_nxt_s == CNT_W'(NB - 1)) begin
            cnt_nxt_s  = {CNT_W{1'b0}};
            full_nxt_s = 1'b1;
         end else begin
            cnt_nxt_s  = cnt_nxt_s + CNT_W'(1);
         end
      end else begin
         cnt_nxt_s = cnt_nxt_s;
      end

      fast_s      = full_nxt_s & ~xfer_full_s & b_free_s;
      load_b_s    = xfer_full_s | fast_s;
      perm_in_s   = xfer_full_s ? a_r : a_nxt_s;
      perm_mode_s = xfer_full_s ? amode_r : mode_nxt_s;

      // A frame completed and forwarded in the same cycle leaves A empty
      if (fast_s) begin
         a_nxt_s    = {N{1'b0}};
         cnt_nxt_s  = {CNT_W{1'b0}};
         full_nxt_s = 1'b0;
      end else begin
         full_nxt_s = full_nxt_s;
      end
   end

   // Assembly register A, its byte counter, full flag and latched mode
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r     <= {N{1'b0}};
         cnt_r   <= {CNT_W{1'b0}};
         full_r  <= 1'b0;
         amode_r <= 1'b0;
      end else begin
         a_r     <= a_nxt_s;
         cnt_r   <= cnt_nxt_s;
         full_r  <= full_nxt_s;
         amode_r <= mode_nxt_s;
      end
   end

   // Output register B: load on hand-off, drop valid when consumed with nothing pending
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_Frame       <= {N{1'b0}};
         o_Frame_Valid <= 1'b0;
         o_Frame_Mode  <= 1'b0;
      end else if (load_b_s) begin
         o_Frame       <= perm_out_s;
         o_Frame_Valid <= 1'b1;
         o_Frame_Mode  <= perm_mode_s;
      end else if (o_Frame_Valid & i_Frame_Ready) begin
         o_Frame_Valid <= 1'b0;
      end
   end

`ifdef BLOCK_INTERLEAVER_RAW_OUT_EN
   // Un-permuted copy of the frame, captured on the same edge as o_Frame
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_Raw_Frame <= {N{1'b0}};
      end else if (load_b_s) begin
         o_Raw_Frame <= perm_in_s;
      end
   end
`endif

   // Sticky overflow flag, set whenever a byte finds A full and blocked
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_Overflow <= 1'b0;
      end else if (drop_s) begin
         o_Overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_block_interleaver.sv
// Self-checking bench for block_interleaver: a frame-level queue model of the
// main 4x16 instance checked every cycle, hand-computed literal checks, and
// interleave/de-interleave round trips on 8x8 and 2x12 instances.
module tb_block_interleaver;

   localparam int R0 = 4;
   localparam int C0 = 16;
   localparam int N0 = R0 * C0;
   localparam int NB0 = N0 / 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  i_Byte = 8'd0;
   logic        i_Byte_Valid = 1'b0;
   logic        i_Deinterleave = 1'b0;
   logic        i_Frame_Abort = 1'b0;
   logic        i_Frame_Ready = 1'b0;
   logic [63:0] o_Frame;
   logic        o_Frame_Valid;
   logic        o_Frame_Mode;
   logic        o_Overflow;
`ifdef BLOCK_INTERLEAVER_RAW_OUT_EN
   logic [63:0] o_Raw_Frame;
   logic [63:0] u1_raw;
   logic [23:0] u2_raw;
`endif

   // Round-trip instances: index 0 is 8x8, index 1 is 2x12
   logic [7:0]  rt_byte [2];
   logic        rt_valid [2];
   logic        rt_mode [2];
   logic        rt_fv [2];
   logic        rt_fm [2];
   logic        rt_ovf [2];
   logic [63:0] u1_frame;
   logic [23:0] u2_frame;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   block_interleaver #(.ROWS(R0), .COLS(C0)) u0 (
      .clk(clk), .rst(rst), .i_Byte(i_Byte), .i_Byte_Valid(i_Byte_Valid),
      .i_Deinterleave(i_Deinterleave), .i_Frame_Abort(i_Frame_Abort),
      .o_Frame(o_Frame), .o_Frame_Valid(o_Frame_Valid), .i_Frame_Ready(i_Frame_Ready),
      .o_Frame_Mode(o_Frame_Mode), .o_Overflow(o_Overflow)
`ifdef BLOCK_INTERLEAVER_RAW_OUT_EN
      , .o_Raw_Frame(o_Raw_Frame)
`endif
   );

   block_interleaver #(.ROWS(8), .COLS(8)) u1 (
      .clk(clk), .rst(rst), .i_Byte(rt_byte[0]), .i_Byte_Valid(rt_valid[0]),
      .i_Deinterleave(rt_mode[0]), .i_Frame_Abort(1'b0),
      .o_Frame(u1_frame), .o_Frame_Valid(rt_fv[0]), .i_Frame_Ready(1'b1),
      .o_Frame_Mode(rt_fm[0]), .o_Overflow(rt_ovf[0])
`ifdef BLOCK_INTERLEAVER_RAW_OUT_EN
      , .o_Raw_Frame(u1_raw)
`endif
   );

   block_interleaver #(.ROWS(2), .COLS(12)) u2 (
      .clk(clk), .rst(rst), .i_Byte(rt_byte[1]), .i_Byte_Valid(rt_valid[1]),
      .i_Deinterleave(rt_mode[1]), .i_Frame_Abort(1'b0),
      .o_Frame(u2_frame), .o_Frame_Valid(rt_fv[1]), .i_Frame_Ready(1'b1),
      .o_Frame_Mode(rt_fm[1]), .o_Overflow(rt_ovf[1])
`ifdef BLOCK_INTERLEAVER_RAW_OUT_EN
      , .o_Raw_Frame(u2_raw)
`endif
   );

   // Reference permutation straight from the row/column rules (n <= 64 bits)
   function automatic logic [63:0] model_perm(input logic [63:0] raw, input int n,
                                              input logic mode, input int rr, input int cc);
      logic [63:0] res;
      int j;
      res = 64'd0;
      for (int k = 0; k < n; k++) begin
         if (mode) j = (k % rr) * cc + (k / rr);
         else      j = (k % cc) * rr + (k / cc);
         res[n-1-j] = raw[n-1-k];
      end
      return res;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // ---------------- frame-level model of u0 ----------------
   logic [7:0]  m_q [$];
   logic        m_amode, m_full, m_bv, m_bm, m_ovf;
   logic [63:0] m_bf, m_braw;

   task automatic m_deliver();
      logic [63:0] raw;
      raw = 64'd0;
      foreach (m_q[i]) raw = (raw << 8) | {56'd0, m_q[i]};
      m_bf   = model_perm(raw, N0, m_amode, R0, C0);
      m_braw = raw;
      m_bv   = 1'b1;
      m_bm   = m_amode;
      m_q.delete();
      m_full = 1'b0;
   endtask

   initial begin
      bit free, was_full, moved;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_q.delete();
            m_amode = 1'b0; m_full = 1'b0; m_bv = 1'b0; m_bm = 1'b0; m_ovf = 1'b0;
            m_bf = 64'd0; m_braw = 64'd0;
         end else begin
            free = !m_bv || i_Frame_Ready;
            was_full = m_full;
            moved = 1'b0;
            if (m_full && free) begin
               m_deliver();
               moved = 1'b1;
            end else if (m_bv && i_Frame_Ready) begin
               m_bv = 1'b0;
            end
            if (i_Frame_Abort && !was_full) begin
               m_q.delete();
            end else if (i_Byte_Valid) begin
               if (!was_full || moved) begin
                  if (m_q.size() == 0) m_amode = i_Deinterleave;
                  m_q.push_back(i_Byte);
                  if (m_q.size() == NB0) m_full = 1'b1;
               end else begin
                  m_ovf = 1'b1;
               end
            end
            if (m_full && !moved && free) m_deliver();
         end
      end
   end

   // Compare u0 against the model on every falling edge
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            chk("cyc_valid", {63'd0, o_Frame_Valid}, {63'd0, m_bv});
            chk("cyc_frame", o_Frame, m_bf);
            chk("cyc_mode", {63'd0, o_Frame_Mode}, {63'd0, m_bm});
            chk("cyc_ovf", {63'd0, o_Overflow}, {63'd0, m_ovf});
`ifdef BLOCK_INTERLEAVER_RAW_OUT_EN
            chk("cyc_raw", o_Raw_Frame, m_braw);
`endif
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send_byte(input logic [7:0] b, input logic mode);
      i_Byte = b;
      i_Deinterleave = mode;
      i_Byte_Valid = 1'b1;
      @(posedge clk); #1;
      i_Byte_Valid = 1'b0;
   endtask

   task automatic send_frame(input logic [63:0] d, input logic mode);
      for (int b = 0; b < NB0; b++) send_byte(d[8*(NB0-1-b) +: 8], mode);
   endtask

   task automatic pulse_abort();
      i_Frame_Abort = 1'b1;
      @(posedge clk); #1;
      i_Frame_Abort = 1'b0;
   endtask

   task automatic rt_frame(input int idx, input logic [63:0] d, input int nb,
                           input logic mode, output logic [63:0] got);
      for (int b = 0; b < nb; b++) begin
         rt_byte[idx] = d[8*(nb-1-b) +: 8];
         rt_mode[idx] = mode;
         rt_valid[idx] = 1'b1;
         @(posedge clk); #1;
         rt_valid[idx] = 1'b0;
      end
      got = (idx == 0) ? u1_frame : {40'd0, u2_frame};
      chk($sformatf("rt%0d_valid", idx), {63'd0, rt_fv[idx]}, 64'd1);
      chk($sformatf("rt%0d_mode", idx), {63'd0, rt_fm[idx]}, {63'd0, mode});
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [63:0] d, g1, g2;
      for (int i = 0; i < 2; i++) begin
         rt_byte[i] = 8'd0; rt_valid[i] = 1'b0; rt_mode[i] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("rst_frame", o_Frame, 64'd0);
      chk("rst_valid", {63'd0, o_Frame_Valid}, 64'd0);
      chk("rst_mode", {63'd0, o_Frame_Mode}, 64'd0);
      chk("rst_ovf", {63'd0, o_Overflow}, 64'd0);
      rst = 1'b0;
      chk_en = 1'b1;

      // Single set bit, interleave then de-interleave
      i_Frame_Ready = 1'b1;
      send_frame(64'h4000_0000_0000_0000, 1'b0);
      chk("il_valid", {63'd0, o_Frame_Valid}, 64'd1);
      chk("il_frame", o_Frame, 64'h0800_0000_0000_0000);
      chk("il_mode", {63'd0, o_Frame_Mode}, 64'd0);
      @(posedge clk); #1;
      chk("il_consumed", {63'd0, o_Frame_Valid}, 64'd0);
      chk("il_kept", o_Frame, 64'h0800_0000_0000_0000);
      send_frame(64'h4000_0000_0000_0000, 1'b1);
      chk("dil_frame", o_Frame, 64'h0000_8000_0000_0000);
      chk("dil_mode", {63'd0, o_Frame_Mode}, 64'd1);
      @(posedge clk); #1;

      // Backpressure: three frames with the consumer stalled
      i_Frame_Ready = 1'b0;
      send_frame(64'h0123_4567_89AB_CDEF, 1'b0);
      send_frame(64'hFEDC_BA98_7654_3210, 1'b1);
      send_frame(64'hA5A5_A5A5_A5A5_A5A5, 1'b0);
      chk("bp_ovf", {63'd0, o_Overflow}, 64'd1);
      chk("bp_f1", o_Frame, model_perm(64'h0123_4567_89AB_CDEF, N0, 1'b0, R0, C0));
      i_Frame_Ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_valid_held", {63'd0, o_Frame_Valid}, 64'd1);
      chk("bp_f2", o_Frame, model_perm(64'hFEDC_BA98_7654_3210, N0, 1'b1, R0, C0));
      chk("bp_f2_mode", {63'd0, o_Frame_Mode}, 64'd1);
      @(posedge clk); #1;
      chk("bp_drained", {63'd0, o_Frame_Valid}, 64'd0);

      // Abort after three bytes, then a fresh frame
      send_byte(8'hFF, 1'b1);
      send_byte(8'hFF, 1'b1);
      send_byte(8'hFF, 1'b1);
      pulse_abort();
      send_frame(64'h4000_0000_0000_0000, 1'b0);
      chk("abort_frame", o_Frame, 64'h0800_0000_0000_0000);
      chk("abort_mode", {63'd0, o_Frame_Mode}, 64'd0);
      @(posedge clk); #1;

      // Abort while A is full is ignored
      i_Frame_Ready = 1'b0;
      send_frame(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      send_frame(64'h4000_0000_0000_0000, 1'b1);
      pulse_abort();
      @(posedge clk); #1;
      chk("afull_hold", o_Frame, 64'hFFFF_FFFF_FFFF_FFFF);
      i_Frame_Ready = 1'b1;
      @(posedge clk); #1;
      chk("afull_frame", o_Frame, 64'h0000_8000_0000_0000);
      chk("afull_valid", {63'd0, o_Frame_Valid}, 64'd1);
      @(posedge clk); #1;

      // Reset during the fifth byte
      for (int b = 0; b < 4; b++) send_byte(8'h11 * b[7:0], 1'b1);
      i_Byte = 8'h55;
      i_Byte_Valid = 1'b1;
      #2 rst = 1'b1;
      @(posedge clk); #1;
      i_Byte_Valid = 1'b0;
      chk("mrst_frame", o_Frame, 64'd0);
      chk("mrst_valid", {63'd0, o_Frame_Valid}, 64'd0);
      chk("mrst_ovf", {63'd0, o_Overflow}, 64'd0);
      rst = 1'b0;
      send_frame(64'h0123_4567_89AB_CDEF, 1'b0);
      chk("mrst_next", o_Frame, model_perm(64'h0123_4567_89AB_CDEF, N0, 1'b0, R0, C0));
`ifdef BLOCK_INTERLEAVER_RAW_OUT_EN
      chk("mrst_raw", o_Raw_Frame, 64'h0123_4567_89AB_CDEF);
`endif
      @(posedge clk); #1;

      // Round trips on 8x8 and 2x12
      for (int t = 0; t < 2; t++) begin
         d = {$urandom, $urandom};
         rt_frame(0, d, 8, 1'b0, g1);
         chk("rt0_il", g1, model_perm(d, 64, 1'b0, 8, 8));
         rt_frame(0, g1, 8, 1'b1, g2);
         chk("rt0_back", g2, d);
         d = {40'd0, 24'($urandom)};
         rt_frame(1, d, 3, 1'b0, g1);
         chk("rt1_il", g1, model_perm(d, 24, 1'b0, 2, 12));
         rt_frame(1, g1, 3, 1'b1, g2);
         chk("rt1_back", g2, d);
      end

      repeat (2) @(posedge clk);
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/block_interleaver.md
# block_interleaver

Parametrised ROWS x COLS block interleaver/de-interleaver for byte streams delivered by the SPI slave receive path. It assembles ROWS*COLS received bits into a frame and applies a row-write/column-read permutation (or its inverse, selected per frame). The permuted frame is presented on a valid/ready output so that one frame can be assembled while the previous one waits for the consumer. It sits between the SPI slave byte pulse and the downstream frame consumer (encoder/modulator).

## Interface
- ROWS, default 8: interleaver matrix rows; ≥2.
- COLS, default 8: interleaver matrix columns; ≥2; ROWS*COLS must be a multiple of 8.
- Derived N = ROWS*COLS frame bits, NB = N/8 bytes per frame.
- Reset is asynchronous and active-high; clock rising edge only.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- i_Byte  in  8  received byte; bit 7 is the first bit on the wire.
- i_Byte_Valid  in  1  single-cycle strobe; i_Byte valid this cycle.
- i_Deinterleave  in  1  0 = interleave, 1 = de-interleave; sampled with the first byte of each frame.
- i_Frame_Abort  in  1  discard the partially assembled frame (e.g. CS_n rising mid-frame).
- o_Frame  out  N  permuted frame; o_Frame[N-1] is output bit j=0.
- o_Frame_Valid  out  1  o_Frame holds an unconsumed frame.
- i_Frame_Ready  in  1  consumer accepts o_Frame when high together with o_Frame_Valid.
- o_Frame_Mode  out  1  mode used for the frame on o_Frame.
- o_Overflow  out  1  sticky: a byte was dropped; cleared only by rst.

## Operation
- Two stages: assembly register A (N bits, byte counter 0..NB-1, full flag, latched mode) and output register B (o_Frame, o_Frame_Valid, o_Frame_Mode).
- Received bit index k: byte b, bit i (i=7 first) gives k = 8b + (7-i).
- Interleave: r = k / COLS, c = k % COLS; output j = c*ROWS + r.
- De-interleave: c = k / ROWS, r = k % ROWS; output j = r*COLS + c (exact inverse of interleave).
- Output bit j is placed on o_Frame[N-1-j].
- Accept: i_Byte_Valid with A not full shifts the byte into A. When the count is 0, the byte also latches i_Deinterleave. On the NB-th byte, A is marked full.
- Transfer A→B occurs when A is full and (B empty, or B is being consumed this cycle). B loads permute(A), o_Frame_Valid=1, and A is cleared.
- A byte arriving in a transfer cycle is accepted as byte 0 of the next frame.
- Drop: i_Byte_Valid while A is full and no transfer occurs this cycle: the byte is discarded and o_Overflow is set.
- i_Frame_Abort: if A is not full, the count is cleared and the bits are discarded. If A is full, the abort is ignored. An abort coinciding with i_Byte_Valid discards that byte as well. B is never affected.
- Consume without a pending A: o_Frame_Valid falls; o_Frame keeps its last value.

## Timing
- Reset values: o_Frame=0, o_Frame_Valid=0, o_Frame_Mode=0, o_Overflow=0; A empty, count 0.
- Latency: last byte strobed in cycle t with B empty gives o_Frame_Valid=1 in cycle t+1.
- Last byte arriving while B is held: transfer on the edge where i_Frame_Ready&o_Frame_Valid; o_Frame_Valid stays 1 continuously.
- Throughput: one frame per NB strobes; strobes may be back-to-back.
- o_Frame and o_Frame_Mode are stable while o_Frame_Valid=1 and i_Frame_Ready=0.
- rst mid-frame: all state returns to reset values immediately; no partial output.

## Configuration
- BLOCK_INTERLEAVER_RAW_OUT_EN defined: adds the output port o_Raw_Frame (N bits, un-permuted A contents, first bit at MSB). It is loaded in the same edge as o_Frame, and its reset value is 0.
- Not defined: the port and its register are absent; all other behaviour is identical.

## Structure
- Package block_interleaver_pkg: constant functions for N/NB, the index functions il_index(k) and dil_index(k), and the parameter legality checks.
- Sub-module block_interleaver_perm: purely combinational N-bit permutation. Its inputs are A and the mode, and it emits permute(A). It is generated by loops from the package functions.
- The top level holds A, B, the counter and the flags.

## Test plan
- ROWS=4, COLS=16, mode 0: bytes 0x40 then 7×0x00 -> o_Frame=0x0800_0000_0000_0000 one cycle after the 8th strobe, o_Frame_Mode=0.
- Same stimulus with mode 1 -> o_Frame=0x0000_8000_0000_0000, o_Frame_Mode=1.
- Round trip: random 8-byte frame interleaved, its output re-sent with mode 1 -> output equals the original; repeat for ROWS=COLS=8 and for ROWS=2, COLS=12 (N=24).
- i_Frame_Ready held 0: send 3 full frames back-to-back -> frame 1 held on B, frame 2 full in A, all 8 bytes of frame 3 dropped, o_Overflow=1. Raise ready -> frame 2 appears on the next edge, o_Frame_Valid stays high.
- Abort after 3 bytes, then 8 new bytes -> output reflects only the new 8 bytes. Abort with A full -> frame retained and delivered.
- Assert rst during byte 5 -> all outputs 0, next 8 bytes produce a correct frame; with BLOCK_INTERLEAVER_RAW_OUT_EN defined, o_Raw_Frame matches the sent bytes.
